mf_loader: RTL and testbench

MF_LOADER -- requirements
Module: mf_loader

---
 rtl/mf_loader.sv | 107 ++++++++++
 tb/tb_mf_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mf_loader.sv
// mf_loader: gathers a stream of (data, weight) elements into fixed-width
// vectors of LANES lanes. A vector is issued once its top lane fills or
// an element arrives flagged "last". Every output comes straight from a flop.
module mf_loader #(
  parameter int LANES = 20,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pushin,
  input  logic [DW-1:0]         din,
  input  logic [DW-1:0]         win,
  input  logic                  last,
  output logic                  pushout,
  output logic [LANES*DW-1:0]   dout,
  output logic [LANES*DW-1:0]   wout,
  output logic [4:0]            lane_cnt,
  output logic [15:0]           vec_cnt
);

  localparam logic [4:0] TOP_LANE = 5'(LANES - 1);

  logic [4:0]  lane_cnt_reg;
  logic [15:0] vec_cnt_reg;
  logic        pushout_reg;
  logic        complete;

  // The vector closes on an accepted element that is either flagged last
  // or lands in the top lane. Both together still count as one completion.
  assign complete = pushin && (last || (lane_cnt_reg == TOP_LANE));

  // Fill pointer, issue counter and the one-cycle output strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt_reg <= '0;
      vec_cnt_reg  <= '0;
      pushout_reg  <= 1'b0;
    end else begin
      pushout_reg <= complete;
      if (complete) begin
        lane_cnt_reg <= '0;
        vec_cnt_reg  <= vec_cnt_reg + 16'd1;
      end else if (pushin) begin
        lane_cnt_reg <= lane_cnt_reg + 5'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [4:0] LANE_IDX = 5'(gi);

      logic [DW-1:0] data_reg;
      logic [DW-1:0] wt_reg;
      logic [DW-1:0] dout_reg;
      logic [DW-1:0] wout_reg;
      logic [DW-1:0] dout_next;
      logic [DW-1:0] wout_next;

      // Lane content on a completing edge: lanes below the incoming one
      // come from storage, the incoming lane takes the live element, and
      // anything above is zeroed so stale data from older vectors never leaks.
      always_comb begin
        dout_next = '0;
        wout_next = '0;
        if (LANE_IDX < lane_cnt_reg) begin
          dout_next = data_reg;
          wout_next = wt_reg;
        end else if (LANE_IDX == lane_cnt_reg) begin
          dout_next = din;
          wout_next = win;
        end
      end

      // Staging storage: captures the element addressed to this lane.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= '0;
          wt_reg   <= '0;
        end else if (pushin && (lane_cnt_reg == LANE_IDX)) begin
          data_reg <= din;
          wt_reg   <= win;
        end
      end

      // Output lane: reloaded only when a vector completes, held otherwise.
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_reg <= '0;
          wout_reg <= '0;
        end else if (complete) begin
          dout_reg <= dout_next;
          wout_reg <= wout_next;
        end
      end

      assign dout[gi*DW +: DW] = dout_reg;
      assign wout[gi*DW +: DW] = wout_reg;
    end
  endgenerate

  assign pushout  = pushout_reg;
  assign lane_cnt = lane_cnt_reg;
  assign vec_cnt  = vec_cnt_reg;

endmodule

// File: tb/tb_mf_loader.sv
// tb_mf_loader: directed checks of mf_loader vector assembly, short
// vectors, back-to-back issue, idle gaps, and mid-vector reset.
module tb_mf_loader;

  localparam int LANES = 20;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            pushin;
  logic [DW-1:0]   din;
  logic [DW-1:0]   win;
  logic            last;
  logic            pushout;
  logic [VW-1:0]   dout;
  logic [VW-1:0]   wout;
  logic [4:0]      lane_cnt;
  logic [15:0]     vec_cnt;

  logic [VW-1:0]   exp_d;
  logic [VW-1:0]   exp_w;
  logic [VW-1:0]   held_d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int pulse_cyc[$];
  int base_pulses;

  mf_loader #(.LANES(LANES), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .pushin   (pushin),
    .din      (din),
    .win      (win),
    .last     (last),
    .pushout  (pushout),
    .dout     (dout),
    .wout     (wout),
    .lane_cnt (lane_cnt),
    .vec_cnt  (vec_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every pushout pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (pushout === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      $display("vector out: cycle=%0d vec_cnt=%0d", cyc, vec_cnt);
    end
  end

  task automatic check_val(input string tag, input logic [VW-1:0] got,
                           input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] w,
                      input logic l);
    pushin = 1'b1;
    din    = d;
    win    = w;
    last   = l;
    @(posedge clk);
    #1;
    pushin = 1'b0;
    last   = 1'b0;
    din    = '0;
    win    = '0;
  endtask

  // Idle cycles with junk on the data lines and last raised.
  task automatic idle(input int n);
    pushin = 1'b0;
    din    = 32'hdeaddead;
    win    = 32'hb0b11111;
    last   = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
    last = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    pushin = 1'b0;
    din    = '0;
    win    = '0;
    last   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pushout", VW'(pushout), '0);
    check_val("rst_dout", dout, '0);
    check_val("rst_wout", wout, '0);
    check_val("rst_lane_cnt", VW'(lane_cnt), '0);
    check_val("rst_vec_cnt", VW'(vec_cnt), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full vector, din=i+1, win=-(i+1)
    exp_d = '0;
    exp_w = '0;
    for (int i = 0; i < LANES; i++) begin
      exp_d[i*DW +: DW] = DW'(i + 1);
      exp_w[i*DW +: DW] = -DW'(i + 1);
    end
    for (int i = 0; i < LANES - 1; i++) push(DW'(i + 1), -DW'(i + 1), 1'b0);
    check_val("full_lane_cnt19", VW'(lane_cnt), VW'(19));
    check_val("full_no_early_pushout", VW'(pushout), '0);
    push(DW'(LANES), -DW'(LANES), 1'b0);
    check_val("full_pushout", VW'(pushout), VW'(1));
    check_val("full_dout", dout, exp_d);
    check_val("full_wout", wout, exp_w);
    check_val("full_wout_lane0", VW'(wout[DW-1:0]), VW'(32'hFFFFFFFF));
    check_val("full_lane_cnt", VW'(lane_cnt), '0);
    check_val("full_vec_cnt", VW'(vec_cnt), VW'(1));
    idle(1);
    check_val("full_pushout_one_cycle", VW'(pushout), '0);
    check_val("full_dout_held", dout, exp_d);
    check_val("full_pulses", VW'(pulses), VW'(1));

    // Short vector closed by last
    push(32'h11, 32'ha1, 1'b0);
    push(32'h22, 32'ha2, 1'b0);
    push(32'h33, 32'ha3, 1'b1);
    exp_d = '0;
    exp_w = '0;
    exp_d[0*DW +: DW] = 32'h11; exp_d[1*DW +: DW] = 32'h22; exp_d[2*DW +: DW] = 32'h33;
    exp_w[0*DW +: DW] = 32'ha1; exp_w[1*DW +: DW] = 32'ha2; exp_w[2*DW +: DW] = 32'ha3;
    check_val("short_pushout", VW'(pushout), VW'(1));
    check_val("short_dout", dout, exp_d);
    check_val("short_wout", wout, exp_w);
    check_val("short_lane_cnt", VW'(lane_cnt), '0);
    check_val("short_vec_cnt", VW'(vec_cnt), VW'(2));

    // last without pushin must be ignored
    push(32'h44, 32'hb4, 1'b0);
    push(32'h55, 32'hb5, 1'b0);
    pushin = 1'b0;
    last   = 1'b1;
    din    = 32'h99;
    @(posedge clk);
    #1;
    last = 1'b0;
    check_val("nolast_lane_cnt", VW'(lane_cnt), VW'(2));
    check_val("nolast_pushout", VW'(pushout), '0);
    check_val("nolast_vec_cnt", VW'(vec_cnt), VW'(2));
    push(32'h66, 32'hb6, 1'b1);
    exp_d = '0;
    exp_w = '0;
    exp_d[0*DW +: DW] = 32'h44; exp_d[1*DW +: DW] = 32'h55; exp_d[2*DW +: DW] = 32'h66;
    exp_w[0*DW +: DW] = 32'hb4; exp_w[1*DW +: DW] = 32'hb5; exp_w[2*DW +: DW] = 32'hb6;
    check_val("nolast_dout", dout, exp_d);
    check_val("nolast_wout", wout, exp_w);
    idle(1);

    // Two full vectors back-to-back
    base_pulses = pulses;
    for (int i = 0; i < LANES; i++) push(DW'(32'h100 + i), DW'(32'h1100 + i), 1'b0);
    for (int i = 0; i < LANES; i++) held_d[i*DW +: DW] = DW'(32'h100 + i);
    check_val("b2b_first_dout", dout, held_d);
    for (int i = 0; i < LANES; i++) begin
      push(DW'(32'h200 + i), DW'(32'h1200 + i), 1'b0);
      if (i == 10) check_val("b2b_first_held", dout, held_d);
    end
    for (int i = 0; i < LANES; i++) begin
      exp_d[i*DW +: DW] = DW'(32'h200 + i);
      exp_w[i*DW +: DW] = DW'(32'h1200 + i);
    end
    check_val("b2b_second_dout", dout, exp_d);
    check_val("b2b_second_wout", wout, exp_w);
    check_val("b2b_vec_cnt", VW'(vec_cnt), VW'(5));
    idle(1);
    check_val("b2b_pulses", VW'(pulses - base_pulses), VW'(2));
    if (pulse_cyc.size() >= 2)
      check_val("b2b_spacing",
                VW'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]),
                VW'(20));

    // Full vector with random idle gaps carrying junk
    base_pulses = pulses;
    for (int i = 0; i < LANES; i++) begin
      idle(int'($urandom_range(10, 0)));
      push(DW'(32'h300 + i), DW'(32'h400 + i), 1'b0);
    end
    for (int i = 0; i < LANES; i++) begin
      exp_d[i*DW +: DW] = DW'(32'h300 + i);
      exp_w[i*DW +: DW] = DW'(32'h400 + i);
    end
    check_val("gap_dout", dout, exp_d);
    check_val("gap_wout", wout, exp_w);
    check_val("gap_vec_cnt", VW'(vec_cnt), VW'(6));
    idle(1);
    check_val("gap_pulses", VW'(pulses - base_pulses), VW'(1));

    // Reset mid-vector, with a push offered during the reset cycle
    base_pulses = pulses;
    for (int i = 0; i < 7; i++) push(DW'(32'h600 + i), DW'(32'h660 + i), 1'b0);
    reset  = 1'b1;
    pushin = 1'b1;
    din    = 32'hbad;
    win    = 32'hbad;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pushin = 1'b0;
    check_val("mrst_lane_cnt", VW'(lane_cnt), '0);
    check_val("mrst_vec_cnt", VW'(vec_cnt), '0);
    check_val("mrst_dout", dout, '0);
    check_val("mrst_pushout", VW'(pushout), '0);
    for (int i = 0; i < LANES; i++) push(DW'(32'h500 + i), DW'(32'h700 + i), 1'b0);
    for (int i = 0; i < LANES; i++) begin
      exp_d[i*DW +: DW] = DW'(32'h500 + i);
      exp_w[i*DW +: DW] = DW'(32'h700 + i);
    end
    check_val("mrst_pushout_after", VW'(pushout), VW'(1));
    check_val("mrst_dout_after", dout, exp_d);
    check_val("mrst_wout_after", wout, exp_w);
    check_val("mrst_vec_cnt_after", VW'(vec_cnt), VW'(1));
    idle(1);
    check_val("mrst_pulses", VW'(pulses - base_pulses), VW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
